i2c_reg_bridge: RTL and testbench

Downstream consumer of the I2C slave front end. It turns the slave's per-byte stream into register-file accesses with a pointer, in the usual "write pointer, then data" I2C register protocol. It holds NUM_REGS 8-bit registers and auto-increments the pointer after every access. On master reads it supplies bytes back to the slave's PISO load path. Local logic can also write the registers through a host port.

---
 rtl/i2c_reg_bridge.sv | 127 ++++++++++++
 tb/tb_i2c_reg_bridge.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_bridge.sv
// i2c_reg_bridge
// Turns the per-byte event stream of an I2C slave front end into accesses
// on a small register file. The protocol is the usual "write pointer, then
// data" scheme. The first byte after a write START loads the pointer. Every
// later byte is written at the pointer. Master reads return the register at
// the pointer. The pointer auto-increments after every data access and wraps
// modulo NUM_REGS. A host port lets local logic write registers directly.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   i2c_start, i2c_rw     START/repeated START pulse and its direction (1 = read)
//   i2c_stop              STOP pulse
//   rx_valid, rx_byte     received byte from the slave SIPO
//   tx_req                slave asks for the next byte to transmit
//   tx_byte, tx_valid     byte for the slave PISO, valid pulse
//   host_we/addr/wdata    local register write port
//   regs_flat             all registers, reg i at [8i+7:8i]
//   wr_strobe, wr_addr    one-cycle notification of a committed I2C write
//   ptr                   current register pointer
module i2c_reg_bridge #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i2c_start,
  input  logic                  i2c_rw,
  input  logic                  i2c_stop,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  tx_req,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [7:0]            host_wdata,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [ADDR_W-1:0]     ptr
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GET_PTR = 2'd1;
  localparam logic [1:0] ST_WR_DATA = 2'd2;
  localparam logic [1:0] ST_RD_DATA = 2'd3;

  logic [1:0] state;
  logic [7:0] regs [NUM_REGS];
  logic       i2c_wr;

  // A data byte is committed only in WR_DATA, and never when a START arrives
  // in the same cycle: the START restarts the transaction and drops the byte.
  assign i2c_wr = (state == ST_WR_DATA) && rx_valid && !i2c_start;

  // Register file. The host write is issued first so that an I2C write to
  // the same register in the same cycle overrides it. Writes to different
  // registers both land.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      if (host_we) begin
        regs[host_addr] <= host_wdata;
      end
      if (i2c_wr) begin
        regs[ptr] <= rx_byte;
      end
    end
  end

  // Transaction FSM, pointer and output pulses. A START takes priority over
  // everything else in its cycle. A STOP lets the current-state action run
  // first, then forces IDLE. The pointer survives both.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      tx_byte   <= 8'h00;
      tx_valid  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      tx_valid  <= 1'b0;
      wr_strobe <= 1'b0;
      if (i2c_start) begin
        state <= i2c_rw ? ST_RD_DATA : ST_GET_PTR;
      end else begin
        case (state)
          ST_GET_PTR: begin
            if (rx_valid) begin
              ptr   <= rx_byte[ADDR_W-1:0];
              state <= ST_WR_DATA;
            end
          end
          ST_WR_DATA: begin
            if (rx_valid) begin
              wr_strobe <= 1'b1;
              wr_addr   <= ptr;
              ptr       <= ptr + ADDR_W'(1);
            end
          end
          ST_RD_DATA: begin
            if (tx_req) begin
              tx_byte  <= regs[ptr];
              tx_valid <= 1'b1;
              ptr      <= ptr + ADDR_W'(1);
            end
          end
          default: begin
          end
        endcase
        if (i2c_stop) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  // Flatten the register array straight from the flops.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// tb_i2c_reg_bridge
// Directed self-checking bench for i2c_reg_bridge with NUM_REGS = 16.
// Each step drives one clock cycle of inputs. Outputs are then sampled 1 ns
// after the rising edge and compared against hand-computed values.
module tb_i2c_reg_bridge;

  logic         clock;
  logic         reset;
  logic         i2c_start;
  logic         i2c_rw;
  logic         i2c_stop;
  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic         tx_req;
  logic [7:0]   tx_byte;
  logic         tx_valid;
  logic         host_we;
  logic [3:0]   host_addr;
  logic [7:0]   host_wdata;
  logic [127:0] regs_flat;
  logic         wr_strobe;
  logic [3:0]   wr_addr;
  logic [3:0]   ptr;

  int           total;
  int           bad;
  logic [127:0] exp_regs;

  i2c_reg_bridge #(.NUM_REGS(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .i2c_start  (i2c_start),
    .i2c_rw     (i2c_rw),
    .i2c_stop   (i2c_stop),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .tx_req     (tx_req),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .regs_flat  (regs_flat),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .ptr        (ptr)
  );

  // 10 ns free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs, wait for the edge plus 1 ns, then return
  // every pulse input to idle.
  task automatic applyStimulus(input logic st, input logic rw, input logic sp,
                               input logic rv, input logic [7:0] rb,
                               input logic tr, input logic hw,
                               input logic [3:0] ha, input logic [7:0] hd);
    i2c_start  = st;
    i2c_rw     = rw;
    i2c_stop   = sp;
    rx_valid   = rv;
    rx_byte    = rb;
    tx_req     = tr;
    host_we    = hw;
    host_addr  = ha;
    host_wdata = hd;
    @(posedge clock);
    #1;
    i2c_start  = 1'b0;
    i2c_rw     = 1'b0;
    i2c_stop   = 1'b0;
    rx_valid   = 1'b0;
    rx_byte    = 8'h00;
    tx_req     = 1'b0;
    host_we    = 1'b0;
    host_addr  = 4'h0;
    host_wdata = 8'h00;
  endtask

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Linear directed sequence
  initial begin
    total      = 0;
    bad        = 0;
    exp_regs   = '0;
    reset      = 1'b1;
    i2c_start  = 1'b0;
    i2c_rw     = 1'b0;
    i2c_stop   = 1'b0;
    rx_valid   = 1'b0;
    rx_byte    = 8'h00;
    tx_req     = 1'b0;
    host_we    = 1'b0;
    host_addr  = 4'h0;
    host_wdata = 8'h00;

    // Reset for one cycle
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("reset_regs", regs_flat, 128'h0);
    checkOutput("reset_ptr", ptr, 0);
    checkOutput("reset_tx_valid", tx_valid, 0);
    checkOutput("reset_wr_strobe", wr_strobe, 0);
    checkOutput("reset_tx_byte", tx_byte, 0);

    // Pointer plus burst write: reg3=AA, reg4=55
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    applyStimulus(0, 0, 0, 1, 8'h03, 0, 0, 4'h0, 8'h00);
    checkOutput("ptr_load", ptr, 3);
    checkOutput("ptr_load_no_strobe", wr_strobe, 0);
    applyStimulus(0, 0, 0, 1, 8'hAA, 0, 0, 4'h0, 8'h00);
    checkOutput("burst1_strobe", wr_strobe, 1);
    checkOutput("burst1_addr", wr_addr, 3);
    checkOutput("burst1_ptr", ptr, 4);
    applyStimulus(0, 0, 0, 1, 8'h55, 0, 0, 4'h0, 8'h00);
    checkOutput("burst2_strobe", wr_strobe, 1);
    checkOutput("burst2_addr", wr_addr, 4);
    applyStimulus(0, 0, 1, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    exp_regs[8*3 +: 8] = 8'hAA;
    exp_regs[8*4 +: 8] = 8'h55;
    checkOutput("burst_regs", regs_flat, exp_regs);
    checkOutput("burst_ptr", ptr, 5);
    checkOutput("burst_strobe_clear", wr_strobe, 0);

    // Wrap-around burst: reg15=11, reg0=22
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    applyStimulus(0, 0, 0, 1, 8'h0F, 0, 0, 4'h0, 8'h00);
    applyStimulus(0, 0, 0, 1, 8'h11, 0, 0, 4'h0, 8'h00);
    checkOutput("wrap_addr", wr_addr, 15);
    checkOutput("wrap_ptr_zero", ptr, 0);
    applyStimulus(0, 0, 0, 1, 8'h22, 0, 0, 4'h0, 8'h00);
    checkOutput("wrap2_addr", wr_addr, 0);
    checkOutput("wrap2_ptr", ptr, 1);
    applyStimulus(0, 0, 1, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    exp_regs[8*15 +: 8] = 8'h11;
    exp_regs[8*0 +: 8]  = 8'h22;
    checkOutput("wrap_regs", regs_flat, exp_regs);

    // Repeated START read from reg3
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    applyStimulus(0, 0, 0, 1, 8'h03, 0, 0, 4'h0, 8'h00);
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    checkOutput("rs_ptr_kept", ptr, 3);
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 0, 4'h0, 8'h00);
    checkOutput("rd1_valid", tx_valid, 1);
    checkOutput("rd1_byte", tx_byte, 8'hAA);
    checkOutput("rd1_ptr", ptr, 4);
    applyStimulus(0, 0, 0, 1, 8'h77, 0, 0, 4'h0, 8'h00);
    checkOutput("rd_gap_valid", tx_valid, 0);
    checkOutput("rd_gap_hold", tx_byte, 8'hAA);
    checkOutput("rd_rx_ignored", regs_flat, exp_regs);
    checkOutput("rd_rx_ptr", ptr, 4);
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 0, 4'h0, 8'h00);
    checkOutput("rd2_valid", tx_valid, 1);
    checkOutput("rd2_byte", tx_byte, 8'h55);
    checkOutput("rd2_ptr", ptr, 5);
    applyStimulus(0, 0, 1, 0, 8'h00, 0, 0, 4'h0, 8'h00);

    // START coincident with rx_valid: byte dropped, back to GET_PTR
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    applyStimulus(0, 0, 0, 1, 8'h03, 0, 0, 4'h0, 8'h00);
    applyStimulus(1, 0, 0, 1, 8'h77, 0, 0, 4'h0, 8'h00);
    checkOutput("st_rx_no_strobe", wr_strobe, 0);
    checkOutput("st_rx_regs", regs_flat, exp_regs);
    checkOutput("st_rx_ptr", ptr, 3);
    applyStimulus(0, 0, 0, 1, 8'h04, 0, 0, 4'h0, 8'h00);
    checkOutput("st_rx_getptr", ptr, 4);
    checkOutput("st_rx_getptr_strobe", wr_strobe, 0);

    // Host and I2C to reg4 together: I2C wins
    applyStimulus(0, 0, 0, 1, 8'h66, 0, 1, 4'h4, 8'h99);
    checkOutput("coll_strobe", wr_strobe, 1);
    checkOutput("coll_addr", wr_addr, 4);
    // Host reg7 and I2C reg5 together: both land
    applyStimulus(0, 0, 0, 1, 8'h77, 0, 1, 4'h7, 8'h5A);
    exp_regs[8*4 +: 8] = 8'h66;
    exp_regs[8*5 +: 8] = 8'h77;
    exp_regs[8*7 +: 8] = 8'h5A;
    checkOutput("host_i2c_regs", regs_flat, exp_regs);
    checkOutput("host_i2c_ptr", ptr, 6);
    applyStimulus(0, 0, 1, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    // Host write while idle: no strobe, pointer untouched
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 1, 4'h9, 8'hE1);
    exp_regs[8*9 +: 8] = 8'hE1;
    checkOutput("host_idle_regs", regs_flat, exp_regs);
    checkOutput("host_idle_strobe", wr_strobe, 0);
    checkOutput("host_idle_ptr", ptr, 6);

    // STOP with rx_valid: byte written, then idle ignores further bytes
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    applyStimulus(0, 0, 0, 1, 8'h0A, 0, 0, 4'h0, 8'h00);
    applyStimulus(0, 0, 1, 1, 8'h3C, 0, 0, 4'h0, 8'h00);
    exp_regs[8*10 +: 8] = 8'h3C;
    checkOutput("stop_rx_strobe", wr_strobe, 1);
    checkOutput("stop_rx_ptr", ptr, 11);
    applyStimulus(0, 0, 0, 1, 8'h44, 0, 0, 4'h0, 8'h00);
    checkOutput("idle_rx_regs", regs_flat, exp_regs);
    checkOutput("idle_rx_strobe", wr_strobe, 0);
    checkOutput("idle_rx_ptr", ptr, 11);

    // Read-after-write: host updates reg11, read starts next cycle
    applyStimulus(1, 1, 0, 0, 8'h00, 0, 1, 4'hB, 8'hD7);
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 0, 4'h0, 8'h00);
    exp_regs[8*11 +: 8] = 8'hD7;
    checkOutput("raw_byte", tx_byte, 8'hD7);
    checkOutput("raw_ptr", ptr, 12);
    applyStimulus(0, 0, 1, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    checkOutput("raw_regs", regs_flat, exp_regs);

    // Reset mid-burst
    applyStimulus(1, 0, 0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    applyStimulus(0, 0, 0, 1, 8'h02, 0, 0, 4'h0, 8'h00);
    applyStimulus(0, 0, 0, 1, 8'hC3, 0, 0, 4'h0, 8'h00);
    exp_regs[8*2 +: 8] = 8'hC3;
    checkOutput("preburst_regs", regs_flat, exp_regs);
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 8'h00, 0, 0, 4'h0, 8'h00);
    reset = 1'b0;
    checkOutput("midrst_regs", regs_flat, 128'h0);
    checkOutput("midrst_ptr", ptr, 0);
    applyStimulus(0, 0, 0, 1, 8'h5E, 0, 0, 4'h0, 8'h00);
    checkOutput("postrst_regs", regs_flat, 128'h0);
    checkOutput("postrst_strobe", wr_strobe, 0);
    applyStimulus(0, 0, 0, 0, 8'h00, 1, 0, 4'h0, 8'h00);
    checkOutput("postrst_tx_valid", tx_valid, 0);
    checkOutput("postrst_ptr", ptr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
